// File: rtl/adder_ctrl.sv
// Register file and chunked ripple-add sequencer sitting behind the AXI4-Lite slave.
// Optional macro ADDER_CTRL_SUB_EN adds a latched SUB mode (A - B via A + ~B + 1).
//
// state    | meaning
// ST_IDLE  | waiting for START; operand and CTRL writes accepted
// ST_RUN   | one CHUNK_WIDTH slice of the sum per cycle into the accumulator
// ST_DONE  | commit accumulator to RESULT, latch carry, pulse done_irq
module adder_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int CHUNK_WIDTH = 8
) (
    input  logic                    ACLK,
    input  logic                    ARST,
    input  logic                    i_en_amba_write,
    input  logic [31:0]             i_addr_wc,
    input  logic [DATA_WIDTH-1:0]   i_data_wc,
    input  logic [DATA_WIDTH/8-1:0] i_strb,
    input  logic [31:0]             i_addr_rc,
    output logic [DATA_WIDTH-1:0]   o_data_rc,
    output logic                    o_is_busy,
    output logic                    o_done_irq
);

    localparam int N_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
    localparam int N_BYTES  = DATA_WIDTH / 8;
    localparam int CNT_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(N_CHUNKS - 1);

    if (DATA_WIDTH % CHUNK_WIDTH != 0) begin : g_bad_chunk
        $error("adder_ctrl: DATA_WIDTH must be a multiple of CHUNK_WIDTH");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0]  opa, opb, result, acc, acc_nxt;
    logic [CNT_W-1:0]       cnt;
    logic                   carry, carry_flag, done;
    logic                   sub_q, sub_start;
    logic [CHUNK_WIDTH-1:0] a_chunk, b_chunk, b_eff;
    logic [CHUNK_WIDTH:0]   chunk_sum;

    logic [1:0] wr_idx, rd_idx;
    logic       ctrl_wr, start_req, clr_req;
    logic       unused_addr;

    assign wr_idx      = i_addr_wc[1:0];
    assign rd_idx      = i_addr_rc[1:0];
    assign unused_addr = ^{i_addr_wc[31:2], i_addr_rc[31:2]};

    assign ctrl_wr   = i_en_amba_write && (wr_idx == 2'd2) && i_strb[0];
    assign start_req = ctrl_wr && i_data_wc[0];
    assign clr_req   = ctrl_wr && i_data_wc[1];

`ifdef ADDER_CTRL_SUB_EN
    assign sub_start = i_data_wc[2];

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            sub_q <= 1'b0;
        end else if (state == ST_IDLE && start_req) begin
            sub_q <= sub_start;
        end
    end
`else
    assign sub_start = 1'b0;
    assign sub_q     = 1'b0;
`endif

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        o_is_busy  = 1'b0;
        o_done_irq = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_req) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                o_is_busy = 1'b1;
                if (cnt == LAST_CHUNK) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                o_is_busy  = 1'b1;
                o_done_irq = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Slice selection by loop keeps indexing width-clean for any chunk count.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < N_CHUNKS; i++) begin
            if (cnt == CNT_W'(i)) begin
                a_chunk = opa[i*CHUNK_WIDTH +: CHUNK_WIDTH];
                b_chunk = opb[i*CHUNK_WIDTH +: CHUNK_WIDTH];
            end
        end
        b_eff     = sub_q ? ~b_chunk : b_chunk;
        chunk_sum = {1'b0, a_chunk} + {1'b0, b_eff} + {{CHUNK_WIDTH{1'b0}}, carry};
        acc_nxt   = acc;
        for (int i = 0; i < N_CHUNKS; i++) begin
            if (cnt == CNT_W'(i)) begin
                acc_nxt[i*CHUNK_WIDTH +: CHUNK_WIDTH] = chunk_sum[CHUNK_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            opa        <= '0;
            opb        <= '0;
            result     <= '0;
            acc        <= '0;
            cnt        <= '0;
            carry      <= 1'b0;
            carry_flag <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_en_amba_write && wr_idx == 2'd0) begin
                        for (int i = 0; i < N_BYTES; i++) begin
                            if (i_strb[i]) opa[i*8 +: 8] <= i_data_wc[i*8 +: 8];
                        end
                    end
                    if (i_en_amba_write && wr_idx == 2'd1) begin
                        for (int i = 0; i < N_BYTES; i++) begin
                            if (i_strb[i]) opb[i*8 +: 8] <= i_data_wc[i*8 +: 8];
                        end
                    end
                    if (clr_req) begin
                        done <= 1'b0;
                    end
                    if (start_req) begin
                        cnt   <= '0;
                        acc   <= '0;
                        carry <= sub_start;
                    end
                end
                ST_RUN: begin
                    acc   <= acc_nxt;
                    carry <= chunk_sum[CHUNK_WIDTH];
                    cnt   <= cnt + CNT_W'(1);
                end
                ST_DONE: begin
                    result     <= acc;
                    carry_flag <= carry;
                    done       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_data_rc = '0;
        case (rd_idx)
            2'd0: o_data_rc = opa;
            2'd1: o_data_rc = opb;
            2'd2: o_data_rc[3:0] = {sub_q, carry_flag, done, o_is_busy};
            2'd3: o_data_rc = result;
            default: o_data_rc = '0;
        endcase
    end

endmodule

// File: tb/tb_adder_ctrl.sv
// Directed bench for adder_ctrl: reset, add, carry chain, strobes, busy lockout,
// mid-operation reset and (with ADDER_CTRL_SUB_EN) subtraction.
module tb_adder_ctrl;

    logic        ACLK = 1'b0;
    logic        ARST = 1'b1;
    logic        i_en_amba_write = 1'b0;
    logic [31:0] i_addr_wc = '0;
    logic [31:0] i_data_wc = '0;
    logic [3:0]  i_strb = '0;
    logic [31:0] i_addr_rc = '0;
    logic [31:0] o_data_rc;
    logic        o_is_busy;
    logic        o_done_irq;

    int n_cmp = 0;
    int n_err = 0;
    int busy_cyc, irq_cnt, irq_pos;

    adder_ctrl dut (
        .ACLK            (ACLK),
        .ARST            (ARST),
        .i_en_amba_write (i_en_amba_write),
        .i_addr_wc       (i_addr_wc),
        .i_data_wc       (i_data_wc),
        .i_strb          (i_strb),
        .i_addr_rc       (i_addr_rc),
        .o_data_rc       (o_data_rc),
        .o_is_busy       (o_is_busy),
        .o_done_irq      (o_done_irq)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_rd(input string tag, input logic [1:0] idx, input logic [31:0] exp);
        i_addr_rc = {30'b0, idx};
        #1;
        check(tag, o_data_rc, exp);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic wr(input logic [1:0] idx, input logic [31:0] data, input logic [3:0] strb);
        i_en_amba_write = 1'b1;
        i_addr_wc       = {30'b0, idx};
        i_data_wc       = data;
        i_strb          = strb;
        @(negedge ACLK);
        i_en_amba_write = 1'b0;
        i_strb          = '0;
    endtask

    // Counts busy cycles and irq pulses until busy drops, bounded.
    task automatic wait_idle();
        busy_cyc = 0;
        irq_cnt  = 0;
        irq_pos  = 0;
        for (int i = 0; i < 20; i++) begin
            if (!o_is_busy) break;
            busy_cyc++;
            if (o_done_irq) begin
                irq_cnt++;
                irq_pos = busy_cyc;
            end
            @(negedge ACLK);
        end
    endtask

    initial begin
        @(negedge ACLK);
        @(negedge ACLK);
        ARST = 1'b0;

        // Dirty every register, then reset.
        wr(2'd0, 32'hDEADBEEF, 4'hF);
        wr(2'd1, 32'h00000001, 4'hF);
        wr(2'd2, 32'h00000001, 4'hF);
        wait_idle();
        ARST = 1'b1;
        @(negedge ACLK);
        @(negedge ACLK);
        ARST = 1'b0;
        check("rst_busy", {31'b0, o_is_busy}, 32'h0);
        check("rst_irq", {31'b0, o_done_irq}, 32'h0);
        check_rd("rst_opa", 2'd0, 32'h0);
        check_rd("rst_opb", 2'd1, 32'h0);
        check_rd("rst_status", 2'd2, 32'h0);
        check_rd("rst_result", 2'd3, 32'h0);

        // Basic add.
        wr(2'd0, 32'h00000005, 4'hF);
        wr(2'd1, 32'h00000003, 4'hF);
        wr(2'd2, 32'h00000001, 4'hF);
        check_rd("busy_status", 2'd2, 32'h1);
        check_rd("busy_result_old", 2'd3, 32'h0);
        wait_idle();
        check("add_busy_cycles", busy_cyc, 5);
        check("add_irq_count", irq_cnt, 1);
        check("add_irq_pos", irq_pos, 5);
        check_rd("add_result", 2'd3, 32'h00000008);
        check_rd("add_status", 2'd2, 32'h2);

        // Full carry ripple through every chunk.
        wr(2'd0, 32'hFFFFFFFF, 4'hF);
        wr(2'd1, 32'h00000001, 4'hF);
        wr(2'd2, 32'h00000001, 4'hF);
        wait_idle();
        check("carry_busy_cycles", busy_cyc, 5);
        check_rd("carry_result", 2'd3, 32'h00000000);
        check_rd("carry_status", 2'd2, 32'h6);

        // CLR_DONE alone, CTRL without strb[0], and RESULT write ignored.
        wr(2'd2, 32'h00000002, 4'hF);
        check_rd("clr_done_status", 2'd2, 32'h4);
        wr(2'd2, 32'h00000001, 4'hE);
        check("nostrb_busy", {31'b0, o_is_busy}, 32'h0);
        wr(2'd3, 32'h12345678, 4'hF);
        check_rd("result_ro", 2'd3, 32'h00000000);

        // Byte strobes.
        wr(2'd0, 32'h11223344, 4'hF);
        wr(2'd0, 32'hAABBCCDD, 4'b0011);
        check_rd("strb_opa", 2'd0, 32'h1122CCDD);
        wr(2'd1, 32'h000033FF, 4'hF);

        // Busy lockout: writes and START during RUN are dropped.
        wr(2'd2, 32'h00000001, 4'hF);
        wr(2'd1, 32'hFFFFFFFF, 4'hF);
        wr(2'd2, 32'h00000001, 4'hF);
        wait_idle();
        check("lock_remaining_busy", busy_cyc, 3);
        check("lock_irq_count", irq_cnt, 1);
        check_rd("lock_result", 2'd3, 32'h112300DC);
        check_rd("lock_opb", 2'd1, 32'h000033FF);
        repeat (3) @(negedge ACLK);
        check("lock_no_restart", {31'b0, o_is_busy}, 32'h0);
        check_rd("lock_status", 2'd2, 32'h2);

        // Reset during the second RUN cycle.
        wr(2'd2, 32'h00000001, 4'hF);
        @(negedge ACLK);
        ARST = 1'b1;
        @(negedge ACLK);
        ARST = 1'b0;
        check("midrst_busy", {31'b0, o_is_busy}, 32'h0);
        check("midrst_irq", {31'b0, o_done_irq}, 32'h0);
        check_rd("midrst_result", 2'd3, 32'h0);
        check_rd("midrst_status", 2'd2, 32'h0);
        repeat (6) @(negedge ACLK);
        check("midrst_no_late_busy", {31'b0, o_is_busy}, 32'h0);

        wr(2'd0, 32'h00000010, 4'hF);
        wr(2'd1, 32'h00000020, 4'hF);
        wr(2'd2, 32'h00000001, 4'hF);
        wait_idle();
        check("post_rst_busy_cycles", busy_cyc, 5);
        check_rd("post_rst_result", 2'd3, 32'h00000030);

        // CTRL bit2 = SUB.
        wr(2'd0, 32'h00000003, 4'hF);
        wr(2'd1, 32'h00000005, 4'hF);
        wr(2'd2, 32'h00000005, 4'hF);
        wait_idle();
        check("sub_busy_cycles", busy_cyc, 5);
`ifdef ADDER_CTRL_SUB_EN
        check_rd("sub_result", 2'd3, 32'hFFFFFFFE);
        check_rd("sub_status", 2'd2, 32'hA);
`else
        check_rd("sub_off_result", 2'd3, 32'h00000008);
        check_rd("sub_off_status", 2'd2, 32'h2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adder_ctrl.md
Name: adder_ctrl

Overview:
- Controller that sequences the adder IP behind the AXI4-Lite slave.
- Captures operand and control writes from the slave's register-write port and runs a multi-cycle chunked (ripple-per-cycle) add.
- Drives busy back to the slave and publishes the result and status on the slave's read-data port.
- Sits between the AXI4-Lite slave and the adder datapath. The register file is owned here.

Parameters:
DATA_WIDTH, 32, operand/result width; must equal slave word size
CHUNK_WIDTH, 8, bits added per cycle; DATA_WIDTH % CHUNK_WIDTH == 0 required (elaboration $error otherwise)
N_CHUNKS, DATA_WIDTH/CHUNK_WIDTH, derived localparam, add cycles per operation

Ports:
ACLK  input  1  clock, all logic on rising edge
ARST  input  1  synchronous reset, active-high
i_en_amba_write  input  1  one-cycle write strobe from slave
i_addr_wc  input  32  write address; register index = bits [1:0]
i_data_wc  input  32  write data
i_strb  input  4  byte enables for the write
i_addr_rc  input  32  read address; register index = bits [1:0]
o_data_rc  output  32  read data, combinational from i_addr_rc
o_is_busy  output  1  high while an operation is in flight
o_done_irq  output  1  one-cycle pulse when a result is committed

Behaviour:
- Register map (index = addr[1:0]):
  - 0 OPA: rw, byte-strobed.
  - 1 OPB: rw, byte-strobed.
  - 2 CTRL/STATUS: write bit0=START, bit1=CLR_DONE, acted on only if i_strb[0]. Read bit0=busy, bit1=done, bit2=carry, others 0.
  - 3 RESULT: ro; writes ignored.
- Reset, ARST high at an edge, including mid-operation:
  - FSM goes to IDLE.
  - OPA, OPB, RESULT, accumulator, chunk counter, carry and done are cleared to 0.
  - o_is_busy=0, o_done_irq=0.
  - Any in-flight operation is discarded.
- Operand writes apply only in IDLE. Each byte lane i updates only when i_strb[i]=1. While busy, writes to OPA/OPB/CTRL are dropped (the slave already answers SLVERR).
- FSM states:
  - IDLE: busy=0. Enters RUN on a START write.
    - Same edge: chunk counter=0, carry_in=0, accumulator=0.
    - If CLR_DONE=1 in the same write, done clears first.
  - RUN: busy=1. Each cycle adds OPA and OPB chunk[cnt] plus the carry, writes the sum into accumulator chunk[cnt], registers carry-out and increments cnt.
    - After chunk N_CHUNKS-1 is written, goes to DONE.
    - RESULT is not touched in RUN, so partial sums are never visible.
  - DONE: busy=1 for exactly one cycle.
    - RESULT<=accumulator, carry flag<=final carry-out, done<=1.
    - o_done_irq=1 for this cycle only.
    - Next state is IDLE.
- Latency: START written on edge k gives busy=1 during cycles k+1 .. k+N_CHUNKS+1, RESULT valid and busy=0 from edge k+N_CHUNKS+2. With defaults that is 5 busy cycles.
- CLR_DONE in IDLE without START clears done only.
- START while busy is ignored; the operation continues unchanged.
- Read path is pure combinational decode with no wait states. Reads while busy return the previous RESULT.

Optional Feature:
ADDER_CTRL_SUB_EN
- Defined:
  - CTRL bit2=SUB is latched on START.
  - With SUB=1, RUN adds OPA + ~OPB with an initial carry_in=1, giving A-B.
  - Status bit2 then holds carry-out (1 = no borrow).
  - Status bit3 reads the latched SUB.
- Undefined: CTRL bit2 is ignored, status bit3 reads 0, and addition only is performed.

Test Plan:
- Reset: ARST high for 2 cycles after random writes, then low -> o_is_busy=0, o_done_irq=0, reads of idx0..3 all return 0x00000000.
- Basic add: OPA=0x00000005, OPB=0x00000003, write CTRL=0x1 -> busy high exactly 5 cycles, o_done_irq one pulse on the 5th, RESULT=0x00000008, status=0x2.
- Carry chain: OPA=0xFFFFFFFF, OPB=0x00000001, START -> RESULT=0x00000000, status=0x6 (done plus carry).
- Strobes and busy lockout:
  - OPA=0x11223344, then write 0xAABBCCDD with strb 0b0011 -> OPA=0x1122CCDD.
  - Start, then during RUN write OPB=0xFFFFFFFF and START -> RESULT reflects the original operands, and only one done pulse occurs.
- Reset mid-op: START, assert ARST on 2nd RUN cycle -> next cycle busy=0, RESULT=0, no o_done_irq; a subsequent START runs normally.
- With ADDER_CTRL_SUB_EN: OPA=0x00000003, OPB=0x00000005, CTRL=0x5 -> RESULT=0xFFFFFFFE, status bit2=0 (borrow), bit3=1.
